// File: rtl/dense_mac_sequencer.sv
// dense_mac_sequencer: time-multiplexed fully-connected layer.
// One signed MAC per cycle, walking synchronous input/weight/bias buffers
// (1-cycle read latency) and streaming one result per neuron over valid/ready.
// Optional build macro DENSE_SAT_EN: clamp the accumulator to the output range
// instead of truncating it. Timing is identical in both builds.
module dense_mac_sequencer #(
    parameter int INPUT_SIZE  = 4096,
    parameter int OUTPUT_SIZE = 128,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 24,
    localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
    localparam int WW = (INPUT_SIZE * OUTPUT_SIZE > 1) ? $clog2(INPUT_SIZE * OUTPUT_SIZE) : 1,
    localparam int BW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [IW-1:0]         in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [WW-1:0]         w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [BW-1:0]         b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BW-1:0]         out_idx,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam logic [IW-1:0] I_LAST = IW'(INPUT_SIZE - 1);
    localparam logic [BW-1:0] J_LAST = BW'(OUTPUT_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t                        state;
    logic [BW-1:0]                 j;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   bias_ext;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic [DATA_WIDTH-1:0]         result;

    // The operands on in_data/w_data always belong to the address issued last cycle.
    assign prod     = $signed(in_data) * $signed(w_data);
    assign prod_ext = ACC_WIDTH'(prod);
    assign bias_ext = ACC_WIDTH'($signed(b_data));
    assign acc_next = acc + prod_ext;

`ifdef DENSE_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    // Clamp the final accumulator into the signed output range.
    always_comb begin
        result = acc_next[DATA_WIDTH-1:0];
        if (acc_next > SAT_MAX)
            result = SAT_MAX[DATA_WIDTH-1:0];
        else if (acc_next < SAT_MIN)
            result = SAT_MIN[DATA_WIDTH-1:0];
    end
`else
    // Truncate the final accumulator to the output width.
    always_comb begin
        result = acc_next[DATA_WIDTH-1:0];
    end
`endif

    // Sequencer FSM; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_addr   <= '0;
            w_addr    <= '0;
            b_addr    <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            acc       <= '0;
            j         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy    <= 1'b1;
                        j       <= '0;
                        b_addr  <= '0;
                        in_addr <= '0;
                        w_addr  <= '0;
                        state   <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    // w_addr is left at j*N-1 by the previous neuron, so one step
                    // lands on j*N without a multiplier.
                    in_addr <= '0;
                    if (j != '0)
                        w_addr <= w_addr + 1'b1;
                    state <= S_MAC;
                end
                S_MAC: begin
                    if (in_addr == '0)
                        acc <= bias_ext;
                    else
                        acc <= acc_next;
                    if (in_addr == I_LAST) begin
                        state <= S_DRAIN;
                    end else begin
                        in_addr <= in_addr + 1'b1;
                        w_addr  <= w_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    acc       <= acc_next;
                    out_data  <= result;
                    out_idx   <= j;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (j == J_LAST) begin
                            state <= S_DONE;
                        end else begin
                            j      <= j + 1'b1;
                            b_addr <= j + 1'b1;
                            state  <= S_BIAS;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_mac_sequencer.sv
// Testbench for dense_mac_sequencer (N=4 inputs, M=2 neurons, 8-bit data).
// Expected results come from a plain-arithmetic layer model pushed into a
// queue at stimulus time; a negedge monitor pops and compares on handshakes.
module tb_dense_mac_sequencer;

    localparam int N = 4;
    localparam int M = 2;

    typedef struct {
        int idx;
        int data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done;
    logic [1:0] in_addr;
    logic [2:0] w_addr;
    logic [0:0] b_addr;
    logic [7:0] in_data = '0, w_data = '0, b_data = '0;
    logic       out_valid, out_ready;
    logic [0:0] out_idx;
    logic [7:0] out_data;

    logic       rand_ready = 1'b0;
    logic       rnd_ready = 1'b1;
    logic       ready_man = 1'b1;

    logic [7:0] in_mem[N];
    logic [7:0] w_mem[N*M];
    logic [7:0] b_mem[M];

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    assign out_ready = rand_ready ? rnd_ready : ready_man;

    dense_mac_sequencer #(
        .INPUT_SIZE(N), .OUTPUT_SIZE(M), .DATA_WIDTH(8), .ACC_WIDTH(24)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous buffers, 1-cycle read latency
    always @(posedge clk) begin
        in_data <= in_mem[in_addr];
        w_data  <= w_mem[w_addr];
        b_data  <= b_mem[b_addr];
    end

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: out_j = conv(wrap24(b_j + sum_i in_i * w_{j*N+i}))
    task automatic push_expected();
        for (int jj = 0; jj < M; jj++) begin
            longint a;
            a = longint'($signed(b_mem[jj]));
            for (int ii = 0; ii < N; ii++)
                a += longint'($signed(in_mem[ii])) * longint'($signed(w_mem[jj*N+ii]));
            a = (a <<< 40) >>> 40;
`ifdef DENSE_SAT_EN
            if (a > 127) a = 127;
            if (a < -128) a = -128;
`endif
            exp_q.push_back('{idx: jj, data: int'(a & 255)});
        end
    endtask

    // scoreboard monitor plus hold-while-stalled checks
    logic       stall = 1'b0;
    logic [7:0] p_data;
    logic [0:0] p_idx;
    logic [1:0] p_ia;
    logic [2:0] p_wa;
    logic [0:0] p_ba;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, p_data);
                chk("stall_idx", out_idx, p_idx);
                chk("stall_in_addr", in_addr, p_ia);
                chk("stall_w_addr", w_addr, p_wa);
                chk("stall_b_addr", b_addr, p_ba);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out actual idx=%0d data=%0h required none", out_idx, out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_idx", out_idx, e.idx);
                    chk("out_data", out_data, e.data);
                end
            end
            stall  = out_valid && !out_ready;
            p_data = out_data;
            p_idx  = out_idx;
            p_ia   = in_addr;
            p_wa   = w_addr;
            p_ba   = b_addr;
        end
    end

    task automatic start_pulse(output int s);
        @(posedge clk);
        #1 start = 1'b1;
        s = cyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input string nm, input int exp_cyc);
        bit got = 0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout actual=no done required=done", nm);
        end else begin
            if (exp_cyc >= 0) chk({nm, "_done_cyc"}, cyc, exp_cyc);
            chk({nm, "_busy_at_done"}, busy, 0);
            @(negedge clk);
            chk({nm, "_done_pulse"}, done, 0);
        end
    endtask

    task automatic load_nominal();
        for (int i = 0; i < N; i++) begin
            in_mem[i]     = 8'd1;
            w_mem[i]      = 8'(i + 1);
            w_mem[N + i]  = 8'hFF;
        end
        b_mem[0] = 8'd5;
        b_mem[1] = 8'd0;
    endtask

    initial begin
        int s;
        int busy_cnt;
        bit found;

        load_nominal();
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_in_addr", in_addr, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_b_addr", b_addr, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // nominal
        push_expected();
        chk("model_n0", exp_q[0].data, 8'h0F);
        chk("model_n1", exp_q[1].data, 8'hFC);
        start_pulse(s);
        wait_done("nominal", s + 15);

        // backpressure: 5 stalled cycles at neuron 0
        ready_man = 1'b0;
        push_expected();
        start_pulse(s);
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (out_valid) found = 1;
        end
        chk("bp_valid_seen", found, 1);
        chk("bp_data", out_data, 8'h0F);
        repeat (5) @(posedge clk);
        #1 ready_man = 1'b1;
        wait_done("backpressure", s + 20);

        // overflow
        for (int i = 0; i < N; i++) begin
            in_mem[i]    = 8'd100;
            w_mem[i]     = 8'd100;
            w_mem[N + i] = 8'(-100);
        end
        b_mem[0] = 8'd0;
        b_mem[1] = 8'd0;
        push_expected();
        start_pulse(s);
        wait_done("overflow", s + 15);

        // start pulsed mid-MAC is ignored
        load_nominal();
        push_expected();
        start_pulse(s);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("midmac", s + 15);
        repeat (3) @(negedge clk);
        chk("midmac_idle", busy, 0);

        // start held through DONE: exactly one follow-up run
        push_expected();
        push_expected();
        @(posedge clk);
        #1 start = 1'b1;
        s = cyc + 1;
        wait_done("held1", s + 15);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("held_rerun_busy", busy, 1);
        wait_done("held2", s + 16 + 15);
        busy_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk("held_no_third_run", busy_cnt, 0);
        chk("held_q_empty", exp_q.size(), 0);

        // reset during neuron 0 MAC cycle 2
        push_expected();
        start_pulse(s);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (busy && in_addr == 2'd2) found = 1;
        end
        chk("rstmid_reached", found, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_valid", out_valid, 0);
        chk("rstmid_in_addr", in_addr, 0);
        chk("rstmid_w_addr", w_addr, 0);
        chk("rstmid_b_addr", b_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_expected();
        start_pulse(s);
        wait_done("after_rst", s + 15);

        // randomized runs with random backpressure
        rand_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) in_mem[i] = 8'($urandom);
            for (int i = 0; i < N*M; i++) w_mem[i] = 8'($urandom);
            for (int i = 0; i < M; i++) b_mem[i] = 8'($urandom);
            push_expected();
            start_pulse(s);
            wait_done("random", -1);
            chk("random_q_empty", exp_q.size(), 0);
        end
        rand_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("final_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dense_mac_sequencer.md
Name: dense_mac_sequencer

Overview:
Time-multiplexed controller/datapath for one fully-connected layer. It replaces the fully-unrolled combinational MAC with a single signed multiply-accumulate per cycle. It walks the input, weight and bias buffers (synchronous RAM/ROM, 1-cycle read latency) and streams one result per output neuron through a valid/ready port. It sits between the flatten stage's input buffer and the next layer's activation buffer.

Parameters:
INPUT_SIZE, 4096, number of input activations per neuron
OUTPUT_SIZE, 128, number of output neurons
DATA_WIDTH, 8, signed width of inputs, weights, biases and outputs
ACC_WIDTH, 24, signed accumulator width (>= 2*DATA_WIDTH)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  start pulse, sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE ends
done  out  1  one-cycle pulse after last neuron accepted
in_addr  out  $clog2(INPUT_SIZE)  input buffer read address
in_data  in  DATA_WIDTH  signed input, valid 1 cycle after in_addr
w_addr  out  $clog2(INPUT_SIZE*OUTPUT_SIZE)  weight address = j*INPUT_SIZE+i
w_data  in  DATA_WIDTH  signed weight, valid 1 cycle after w_addr
b_addr  out  $clog2(OUTPUT_SIZE)  bias address = j
b_data  in  DATA_WIDTH  signed bias, valid 1 cycle after b_addr
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_idx  out  $clog2(OUTPUT_SIZE)  neuron index j of out_data
out_data  out  DATA_WIDTH  signed neuron result

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, done and out_valid are 0. All addresses, out_idx and out_data are 0. Accumulator, i and j are 0. Reset mid-run aborts with no partial output.
- FSM states: IDLE, BIAS, MAC, DRAIN, OUT, DONE.
- IDLE: on start=1, set j=0 and go to BIAS. start in any other state is ignored.
- BIAS (1 cycle): drive b_addr=j, then go to MAC with i=0.
- MAC (INPUT_SIZE cycles, k=0..N-1): drive in_addr=k and w_addr=j*N+k.
  - k=0: acc <= sign-extended b_data.
  - k>0: acc += in_data*w_data, the product of the operands returned for address k-1.
  - After k=N-1, go to DRAIN.
- DRAIN (1 cycle): acc += final product. out_data <= result conversion of acc, out_idx <= j. Go to OUT.
- OUT: out_valid=1. out_data and out_idx are held stable until out_ready=1. No addresses change while stalled.
  - On handshake: if j==OUTPUT_SIZE-1, go to DONE. Otherwise j++ and go to BIAS.
  - out_valid drops in the cycle after the handshake.
- DONE (1 cycle): done=1, busy=0 in the following cycle, then IDLE.
- Arithmetic: products are signed DATA_WIDTH x DATA_WIDTH, sign-extended to ACC_WIDTH. The accumulator wraps two's-complement on overflow.
- Result conversion (default): out_data = acc[DATA_WIDTH-1:0], i.e. truncation.
- Timing: with out_ready tied high, each neuron takes INPUT_SIZE+3 cycles. done asserts OUTPUT_SIZE*(INPUT_SIZE+3)+1 cycles after the start edge.
- Boundaries:
  - start and out_ready high together in DONE: start is ignored; a new run needs start in IDLE.
  - INPUT_SIZE=1: MAC lasts 1 cycle.
  - OUTPUT_SIZE=1: OUT goes directly to DONE.

Optional Feature:
DENSE_SAT_EN. When defined, out_data is acc clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] instead of truncated. Timing is unchanged; the clamp is registered in DRAIN. When undefined, truncation applies as above.

Test Plan:
- Params for all tests: INPUT_SIZE=4, OUTPUT_SIZE=2, DATA_WIDTH=8.
- Nominal run: inputs {1,1,1,1}, weights n0={1,2,3,4}, n1={-1,-1,-1,-1}, biases {5,0}, out_ready=1 -> (idx0, 0x0F) then (idx1, 0xFC). done in cycle 15 after the start edge, busy low afterwards.
- Backpressure: as nominal, out_ready=0 for 5 cycles at neuron 0 -> out_valid held with data stable at 0x0F, addresses frozen. done in cycle 20.
- Overflow: inputs all 100, weights n0 all 100, n1 all -100, biases 0 -> acc +40000 / -40000.
  - Default: out_data 0x40 / 0xC0.
  - With DENSE_SAT_EN: 0x7F / 0x80.
- Start handling: start pulsed mid-MAC -> ignored, results match nominal. start held high through DONE -> exactly one new run begins from IDLE.
- Reset mid-run: rst_n=0 during neuron 0 MAC cycle 2 -> busy, out_valid and addresses are 0 immediately. Subsequent start reproduces the nominal results.
